eth_udp_hdr_tx: RTL and testbench

Transmit-side header builder, the counterpart of the receive parser whose flow-key fields (DST_MAC, SRC_MAC, ETH_TYPE, SRC_IP, DST_IP, SRC_PORT/DST_PORT) are exposed in the CSR map. The block takes the same fields as CSR-driven configuration and emits a byte-wide AXI4-Stream frame. The frame carries an Ethernet header, and for IPv4 also an IPv4 header with a computed checksum and a UDP header, followed by payload passed through from an upstream stream. It sits between the PS-fed payload FIFO and the MAC TX stream.

---
 rtl/eth_udp_hdr_tx_if.sv | 21 ++
 rtl/eth_udp_hdr_tx.sv | 269 ++++++++++++++++++++++++++
 tb/tb_eth_udp_hdr_tx.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_udp_hdr_tx_if.sv
// ---------------------------------------------------------------------------
// eth_udp_hdr_tx_if
// Byte-wide AXI4-Stream bundle used for both the payload input and the frame
// output of eth_udp_hdr_tx.
//   tdata  [7:0] : data byte
//   tvalid       : source has a valid byte
//   tready       : sink accepts the byte
//   tlast        : byte is the last of the frame
// Modports:
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface eth_udp_hdr_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_udp_hdr_tx.sv
// ---------------------------------------------------------------------------
// eth_udp_hdr_tx
// Transmit-side header builder. On start it latches the cfg_* fields, spends
// one cycle computing lengths and the IPv4 header checksum, then emits an
// Ethernet header (plus IPv4 + UDP headers when eth_type == 0x0800) as a
// registered byte stream, followed by a combinational pass-through of the
// upstream payload stream.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_dst_mac/src_mac/eth_type/src_ip/dst_ip/src_port/dst_port
//                     : header fields, MSB byte sent first
//   cfg_payload_len   : payload byte count (0 = header-only frame)
//   start             : one-cycle send request, honoured only when idle
//   busy              : high from start acceptance through the tlast beat
//   len_err           : one-cycle pulse when the payload tlast arrives at a
//                       count different from cfg_payload_len
//   s_axis            : payload input stream (slave)
//   m_axis            : frame output stream (master)
//
// Build option: define TX_LEN_CHECK_EN to build the payload length checker;
// without it len_err is tied low.
// ---------------------------------------------------------------------------
module eth_udp_hdr_tx #(
  parameter logic [7:0] TTL = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] cfg_dst_mac,
  input  logic [47:0] cfg_src_mac,
  input  logic [15:0] cfg_eth_type,
  input  logic [31:0] cfg_src_ip,
  input  logic [31:0] cfg_dst_ip,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
  input  logic [15:0] cfg_payload_len,
  input  logic        start,
  output logic        busy,
  output logic        len_err,
  eth_udp_hdr_tx_if.slave  s_axis,
  eth_udp_hdr_tx_if.master m_axis
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HDR  = 2'd2;
  localparam logic [1:0] PAY  = 2'd3;

  logic [1:0]  state_reg;

  // Latched configuration
  logic [47:0] dst_mac_reg;
  logic [47:0] src_mac_reg;
  logic [15:0] eth_type_reg;
  logic [31:0] src_ip_reg;
  logic [31:0] dst_ip_reg;
  logic [15:0] src_port_reg;
  logic [15:0] dst_port_reg;
  logic [15:0] payload_len_reg;

  // Values derived in CALC
  logic [15:0] total_len_reg;
  logic [15:0] udp_len_reg;
  logic [15:0] csum_reg;
  logic [5:0]  hdr_len_reg;
  logic        is_ipv4_reg;

  logic [15:0] ip_id_reg;

  // Registered header output stage; hdr_idx_reg is the index of the next
  // byte to load, so it equals hdr_len_reg once the final byte is loaded.
  logic [5:0]  hdr_idx_reg;
  logic [7:0]  hdr_data_reg;
  logic        hdr_valid_reg;
  logic        hdr_last_reg;

  // ---------------------------------------------------------------------
  // Length and checksum arithmetic (used during CALC)
  // ---------------------------------------------------------------------
  logic [15:0] total_len_next;
  logic [15:0] udp_len_next;
  logic [19:0] csum_sum;
  logic [16:0] csum_fold1;
  logic [16:0] csum_fold2;
  logic [15:0] csum_next;

  assign total_len_next = 16'd28 + payload_len_reg;
  assign udp_len_next   = 16'd8 + payload_len_reg;

  // Ten header words with the checksum word taken as zero. Ten 16-bit
  // words never exceed 20 bits; two end-around folds always suffice.
  assign csum_sum = 20'h04500
                  + {4'h0, total_len_next}
                  + {4'h0, ip_id_reg}
                  + 20'h04000
                  + {4'h0, TTL, 8'h11}
                  + {4'h0, src_ip_reg[31:16]}
                  + {4'h0, src_ip_reg[15:0]}
                  + {4'h0, dst_ip_reg[31:16]}
                  + {4'h0, dst_ip_reg[15:0]};
  assign csum_fold1 = {1'b0, csum_sum[15:0]} + {13'd0, csum_sum[19:16]};
  assign csum_fold2 = {1'b0, csum_fold1[15:0]} + {16'd0, csum_fold1[16]};
  assign csum_next  = ~csum_fold2[15:0];

  // ---------------------------------------------------------------------
  // Header byte table: 42 bytes, byte 0 is the MSB of the vector
  // ---------------------------------------------------------------------
  logic [335:0] hdr_vec;
  logic [7:0]   hdr_bytes [0:63];

  assign hdr_vec = {dst_mac_reg, src_mac_reg, eth_type_reg,
                    8'h45, 8'h00, total_len_reg, ip_id_reg, 16'h4000,
                    TTL, 8'h11, csum_reg, src_ip_reg, dst_ip_reg,
                    src_port_reg, dst_port_reg, udp_len_reg, 16'h0000};

  // Padded to 64 entries so the 6-bit index never leaves the table.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_hdr_bytes
      if (gi < 42) begin : g_used
        assign hdr_bytes[gi] = hdr_vec[335 - 8*gi -: 8];
      end else begin : g_pad
        assign hdr_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  logic hdr_load_last;
  assign hdr_load_last = (payload_len_reg == 16'd0) &&
                         (hdr_idx_reg == hdr_len_reg - 6'd1);

`ifdef TX_LEN_CHECK_EN
  logic [15:0] pay_cnt_reg;
  logic        len_err_reg;
  assign len_err = len_err_reg;
`else
  assign len_err = 1'b0;
`endif

  logic pay_xfer;
  assign pay_xfer = (state_reg == PAY) && s_axis.tvalid && m_axis.tready;

  // ---------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      dst_mac_reg     <= '0;
      src_mac_reg     <= '0;
      eth_type_reg    <= '0;
      src_ip_reg      <= '0;
      dst_ip_reg      <= '0;
      src_port_reg    <= '0;
      dst_port_reg    <= '0;
      payload_len_reg <= '0;
      total_len_reg   <= '0;
      udp_len_reg     <= '0;
      csum_reg        <= '0;
      hdr_len_reg     <= '0;
      is_ipv4_reg     <= 1'b0;
      ip_id_reg       <= '0;
      hdr_idx_reg     <= '0;
      hdr_data_reg    <= 8'h00;
      hdr_valid_reg   <= 1'b0;
      hdr_last_reg    <= 1'b0;
`ifdef TX_LEN_CHECK_EN
      pay_cnt_reg     <= '0;
      len_err_reg     <= 1'b0;
`endif
    end else begin
`ifdef TX_LEN_CHECK_EN
      len_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (start) begin
            dst_mac_reg     <= cfg_dst_mac;
            src_mac_reg     <= cfg_src_mac;
            eth_type_reg    <= cfg_eth_type;
            src_ip_reg      <= cfg_src_ip;
            dst_ip_reg      <= cfg_dst_ip;
            src_port_reg    <= cfg_src_port;
            dst_port_reg    <= cfg_dst_port;
            payload_len_reg <= cfg_payload_len;
            state_reg       <= CALC;
          end
        end

        CALC: begin
          total_len_reg <= total_len_next;
          udp_len_reg   <= udp_len_next;
          csum_reg      <= csum_next;
          is_ipv4_reg   <= (eth_type_reg == 16'h0800);
          hdr_len_reg   <= (eth_type_reg == 16'h0800) ? 6'd42 : 6'd14;
          hdr_idx_reg   <= '0;
          hdr_valid_reg <= 1'b0;
          hdr_last_reg  <= 1'b0;
`ifdef TX_LEN_CHECK_EN
          pay_cnt_reg   <= '0;
`endif
          state_reg     <= HDR;
        end

        HDR: begin
          // Output stage is free when empty or its byte is being accepted.
          if (!hdr_valid_reg || m_axis.tready) begin
            if (hdr_idx_reg == hdr_len_reg) begin
              // Final header byte has just been accepted.
              hdr_valid_reg <= 1'b0;
              hdr_last_reg  <= 1'b0;
              if (payload_len_reg == 16'd0) begin
                state_reg <= IDLE;
                if (is_ipv4_reg) begin
                  ip_id_reg <= ip_id_reg + 16'd1;
                end
              end else begin
                state_reg <= PAY;
              end
            end else begin
              hdr_data_reg  <= hdr_bytes[hdr_idx_reg];
              hdr_valid_reg <= 1'b1;
              hdr_last_reg  <= hdr_load_last;
              hdr_idx_reg   <= hdr_idx_reg + 6'd1;
            end
          end
        end

        PAY: begin
          if (pay_xfer) begin
`ifdef TX_LEN_CHECK_EN
            pay_cnt_reg <= pay_cnt_reg + 16'd1;
`endif
            if (s_axis.tlast) begin
              state_reg <= IDLE;
              if (is_ipv4_reg) begin
                ip_id_reg <= ip_id_reg + 16'd1;
              end
`ifdef TX_LEN_CHECK_EN
              if ((pay_cnt_reg + 16'd1) != payload_len_reg) begin
                len_err_reg <= 1'b1;
              end
`endif
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output mux: registered header bytes, combinational payload path
  // ---------------------------------------------------------------------
  assign busy          = (state_reg != IDLE);
  assign s_axis.tready = (state_reg == PAY) && m_axis.tready;

  always_comb begin
    m_axis.tdata  = hdr_data_reg;
    m_axis.tvalid = hdr_valid_reg;
    m_axis.tlast  = hdr_last_reg;
    if (state_reg == PAY) begin
      m_axis.tdata  = s_axis.tdata;
      m_axis.tvalid = s_axis.tvalid;
      m_axis.tlast  = s_axis.tlast;
    end
  end

endmodule

// File: tb/tb_eth_udp_hdr_tx.sv
// ---------------------------------------------------------------------------
// tb_eth_udp_hdr_tx
// Directed bench for eth_udp_hdr_tx. Expected frames come from a hand-written
// header image with per-frame ip_id / checksum bytes patched in from
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_eth_udp_hdr_tx;

  logic        clk;
  logic        rst;
  logic [47:0] cfg_dst_mac;
  logic [47:0] cfg_src_mac;
  logic [15:0] cfg_eth_type;
  logic [31:0] cfg_src_ip;
  logic [31:0] cfg_dst_ip;
  logic [15:0] cfg_src_port;
  logic [15:0] cfg_dst_port;
  logic [15:0] cfg_payload_len;
  logic        start;
  logic        busy;
  logic        len_err;

  eth_udp_hdr_tx_if s_if ();
  eth_udp_hdr_tx_if m_if ();

  eth_udp_hdr_tx dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_dst_mac     (cfg_dst_mac),
    .cfg_src_mac     (cfg_src_mac),
    .cfg_eth_type    (cfg_eth_type),
    .cfg_src_ip      (cfg_src_ip),
    .cfg_dst_ip      (cfg_dst_ip),
    .cfg_src_port    (cfg_src_port),
    .cfg_dst_port    (cfg_dst_port),
    .cfg_payload_len (cfg_payload_len),
    .start           (start),
    .busy            (busy),
    .len_err         (len_err),
    .s_axis          (s_if),
    .m_axis          (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Header image for the IPv4 test config, ip_id 0, payload_len 4.
  logic [335:0] hdr_a;
  logic [7:0]   pay[$];
  logic [8:0]   exp_q[$];
  logic [8:0]   got_q[$];
  int first_k, last_k, tready_seen, stall_bad, busy_k0, busy_k1;
  int len_err_cnt, idle_valid_cnt;

  task automatic set_cfg(input logic [15:0] eth, input logic [15:0] plen);
    cfg_dst_mac     = 48'h001122334455;
    cfg_src_mac     = 48'h0A0B0C0D0E0F;
    cfg_eth_type    = eth;
    cfg_src_ip      = 32'hC0A8010A;   // 192.168.1.10
    cfg_dst_ip      = 32'hC0A80114;   // 192.168.1.20
    cfg_src_port    = 16'h1234;
    cfg_dst_port    = 16'h5678;
    cfg_payload_len = plen;
  endtask

  task automatic set_pay(input int n);
    pay.delete();
    if (n == 4) begin
      pay.push_back(8'hDE); pay.push_back(8'hAD);
      pay.push_back(8'hBE); pay.push_back(8'hEF);
    end else begin
      for (int i = 0; i < n; i++) pay.push_back(8'(i + 1));
    end
  endtask

  // IPv4 frame with 4-byte payload; id and checksum supplied by the caller.
  task automatic build_ipv4(input logic [15:0] id, input logic [15:0] csum);
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < 42; i++) begin
      b = hdr_a[335 - 8*i -: 8];
      if (i == 18) b = id[15:8];
      if (i == 19) b = id[7:0];
      if (i == 24) b = csum[15:8];
      if (i == 25) b = csum[7:0];
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b0, 8'hDE});
    exp_q.push_back({1'b0, 8'hAD});
    exp_q.push_back({1'b0, 8'hBE});
    exp_q.push_back({1'b1, 8'hEF});
  endtask

  // Runs one frame starting from posedge+#1; returns at posedge+#1 right
  // after the edge that accepted the tlast beat.
  task automatic run_frame(input bit bp, input bit gap, input int ign_a, input int ign_b);
    int pi;
    bit done, prev_stall, s_hs;
    logic [7:0] prev_d;
    logic prev_l;
    got_q.delete();
    first_k = -1; last_k = -1; tready_seen = 0; stall_bad = 0;
    busy_k0 = -1; busy_k1 = -1;
    pi = 0; done = 0; prev_stall = 0; prev_d = 8'h00; prev_l = 1'b0;
    start = 1'b1;
    s_if.tdata  = (pay.size() > 0) ? pay[0] : 8'h00;
    s_if.tlast  = (pay.size() == 1);
    s_if.tvalid = (pay.size() > 0) ? (gap ? ($urandom_range(0, 2) != 0) : 1'b1) : 1'b0;
    m_if.tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (k == 0) busy_k0 = int'(busy);
      if (k == 1) busy_k1 = int'(busy);
      if (len_err) len_err_cnt++;
      if (s_if.tready) tready_seen++;
      if (prev_stall && (!m_if.tvalid || m_if.tdata != prev_d || m_if.tlast != prev_l))
        stall_bad++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_d = m_if.tdata;
      prev_l = m_if.tlast;
      s_hs = s_if.tvalid && s_if.tready;
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back({m_if.tlast, m_if.tdata});
        if (first_k < 0) first_k = k;
        last_k = k;
        if (m_if.tlast) done = 1;
      end
      @(posedge clk);
      #1;
      start = ((k + 1) == ign_a) || ((k + 1) == ign_b);
      if (s_hs) pi++;
      if (pi < pay.size()) begin
        if (!s_if.tvalid || s_hs)
          s_if.tvalid = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_if.tdata = pay[pi];
        s_if.tlast = (pi == pay.size() - 1);
      end else begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
      end
      m_if.tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    start = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    if (!done) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_frame(input string tag);
    int n;
    $display("frame %s: %0d beats, first beat at cycle %0d, last at cycle %0d",
             tag, got_q.size(), first_k, last_k);
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (len_err) len_err_cnt++;
      if (m_if.tvalid || busy) idle_valid_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    hdr_a = 336'h001122334455_0A0B0C0D0E0F_0800_4500_0020_0000_4000_4011_B75E_C0A8010A_C0A80114_1234_5678_000C_0000;
    rst = 1'b1;
    start = 1'b0;
    s_if.tdata = 8'h00; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    set_cfg(16'h0800, 16'd4);
    len_err_cnt = 0; idle_valid_cnt = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    {31'd0, busy},        32'd0);
    check("rst_len_err", {31'd0, len_err},     32'd0);
    check("rst_mvalid",  {31'd0, m_if.tvalid}, 32'd0);
    check("rst_mlast",   {31'd0, m_if.tlast},  32'd0);
    check("rst_sready",  {31'd0, s_if.tready}, 32'd0);
    check("rst_mdata",   {24'd0, m_if.tdata},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // A: IPv4, no backpressure, id 0
    set_cfg(16'h0800, 16'd4); set_pay(4); build_ipv4(16'h0000, 16'hB75E);
    run_frame(0, 0, -1, -1);
    cmp_frame("A");
    check("A_busy_after_start", busy_k1, 32'd1);
    check("A_first_beat_cycle", first_k, 32'd3);
    check("A_last_beat_cycle",  last_k,  32'd48);

    // B: non-IPv4 header-only frame, starts the cycle after A's tlast
    set_cfg(16'h88B5, 16'd0); set_pay(0);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, hdr_a[335 - 8*i -: 8]});
    exp_q.push_back({1'b0, 8'h88});
    exp_q.push_back({1'b1, 8'hB5});
    run_frame(0, 0, -1, -1);
    cmp_frame("B");
    check("B_busy_at_start", busy_k0, 32'd0);
    check("B_sready_seen", tready_seen, 32'd0);
    check("B_first_beat_cycle", first_k, 32'd3);

    // C: IPv4 with random backpressure and gapped payload, id 1
    set_cfg(16'h0800, 16'd4); set_pay(4); build_ipv4(16'h0001, 16'hB75D);
    run_frame(1, 1, -1, -1);
    cmp_frame("C");
    check("C_stall_stable", stall_bad, 32'd0);

    // E: back-to-back start in the cycle after C's tlast, id 2
    build_ipv4(16'h0002, 16'hB75C);
    run_frame(0, 0, -1, -1);
    cmp_frame("E");
    check("E_first_beat_cycle", first_k, 32'd3);

    // D: start pulses during HDR (cycle 10) and PAY (cycle 46) ignored, id 3
    build_ipv4(16'h0003, 16'hB75B);
    run_frame(0, 0, 10, 46);
    cmp_frame("D");
    idle_valid_cnt = 0;
    idle(6);
    check("D_no_extra_frame", idle_valid_cnt, 32'd0);

    // F: reset asserted while the header is being sent
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("F_in_hdr_before_rst", {31'd0, m_if.tvalid}, 32'd1);
    rst = 1'b1;
    #1;
    check("F_rst_mvalid", {31'd0, m_if.tvalid}, 32'd0);
    check("F_rst_mlast",  {31'd0, m_if.tlast},  32'd0);
    check("F_rst_mdata",  {24'd0, m_if.tdata},  32'd0);
    check("F_rst_busy",   {31'd0, busy},        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // G: clean frame after reset, ip_id back to 0
    build_ipv4(16'h0000, 16'hB75E);
    run_frame(0, 0, -1, -1);
    cmp_frame("G");

    // H/I: ip_id preset to 0xFFFF, then wraps to 0x0000
    force dut.ip_id_reg = 16'hFFFF;
    #1;
    release dut.ip_id_reg;
    build_ipv4(16'hFFFF, 16'hB75E);
    run_frame(0, 0, -1, -1);
    cmp_frame("H");
    build_ipv4(16'h0000, 16'hB75E);
    run_frame(0, 0, -1, -1);
    cmp_frame("I");

    // L1: payload_len 8, tlast on the 6th byte
    set_cfg(16'h0800, 16'd8); set_pay(6);
    len_err_cnt = 0;
    run_frame(0, 0, -1, -1);
    idle(3);
    $display("frame L1: %0d beats, len_err cycles %0d", got_q.size(), len_err_cnt);
    check("L1_beats", got_q.size(), 32'd48);
    check("L1_last_beat", (got_q.size() > 0) ? {23'd0, got_q[got_q.size()-1]} : 32'd0, 32'h106);
`ifdef TX_LEN_CHECK_EN
    check("L1_len_err_pulse", len_err_cnt, 32'd1);
`else
    check("L1_len_err_pulse", len_err_cnt, 32'd0);
`endif

    // L2: payload_len 8, tlast on the 8th byte
    set_pay(8);
    len_err_cnt = 0;
    run_frame(0, 0, -1, -1);
    idle(3);
    $display("frame L2: %0d beats, len_err cycles %0d", got_q.size(), len_err_cnt);
    check("L2_beats", got_q.size(), 32'd50);
    check("L2_len_err_pulse", len_err_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
